// File: rtl/wb_spi_sram_pkg.sv
// wb_spi_sram_pkg: shared FSM states, SPI opcodes, Wishbone cycle types and header length for wb_spi_sram
package wb_spi_sram_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, ACK, HOLD, DESEL} state_t;
  localparam logic [7:0] SPI_READ = 8'h03;
  localparam logic [7:0] SPI_WRITE = 8'h02;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  localparam int HDR_BITS = 32;
endpackage

// File: rtl/wb_spi_sram_bit.sv
// spi_bit_engine: mode-0 MSB-first shifter (load/clr/len/data, miso in; sck/mosi out, done pulse, rx byte)
module spi_bit_engine
  import wb_spi_sram_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                clr,
  input  logic [5:0]          len,
  input  logic [HDR_BITS-1:0] data,
  input  logic                miso,
  output logic                sck,
  output logic                mosi,
  output logic                done,
  output logic [7:0]          rx
);
  logic [HDR_BITS-1:0] sh;
  logic [4:0] cnt;
  logic busy;
  assign done = busy & sck & (cnt == 5'd0);
  assign rx = {sh[6:0], miso};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0;
      cnt <= '0;
      busy <= 1'b0;
      sck <= 1'b0;
      mosi <= 1'b0;
    end else if (clr) begin
      busy <= 1'b0;
      sck <= 1'b0;
      mosi <= 1'b0;
    end else if (load) begin
      sh <= data;
      cnt <= 5'(len - 6'd1);
      busy <= 1'b1;
      sck <= 1'b0;
      mosi <= data[HDR_BITS-1];
    end else if (busy) begin
      sck <= !sck;
      if (sck) begin
        sh <= {sh[HDR_BITS-2:0], miso};
        cnt <= cnt - 5'd1;
        busy <= cnt != 5'd0;
        mosi <= (cnt != 5'd0) & sh[HDR_BITS-2];
      end
    end
endmodule

// File: rtl/wb_spi_sram.sv
// wb_spi_sram: Wishbone B4 byte slave (cyc/stb/we/adr/sel/dat/cti in; ack/dat out) streaming onto an SPI SRAM (sck/cs_n/mosi/miso)
module wb_spi_sram
  import wb_spi_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic                  wbs_sel_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [2:0]            wbs_cti_i,
  input  logic [1:0]            wbs_bte_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic                  spi_sck_o,
  output logic                  spi_cs_no,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);
  state_t state;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [7:0] dat_q, rx, pay;
  logic [HDR_BITS-1:0] ld_data;
  logic we_q, dcnt, done, load, clr, req, idle_go, hold_go, hdr_next, unused;
  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;
  assign unused = ^wbs_bte_i;
  assign req = wbs_cyc_i & wbs_stb_i;
  assign idle_go = (state == IDLE) & req & (!wbs_we_i | wbs_sel_i);
  assign hold_go = (state == HOLD) & req & (wbs_we_i == we_q) & (!wbs_we_i | wbs_sel_i)
                 & (wbs_adr_i == adr_q + ADDR_WIDTH'(1));
  assign hdr_next = (state == HDR) & wbs_cyc_i & done;
  assign clr = (state == HDR || state == DATA) & !wbs_cyc_i;
  assign load = idle_go | hold_go | hdr_next;
  assign pay = !we_q ? 8'h00 : state == HOLD ? wbs_dat_i : dat_q;
  assign ld_data = state == IDLE ? {wbs_we_i ? SPI_WRITE : SPI_READ, wbs_adr_i} : {pay, {(HDR_BITS-8){1'b0}}};
  spi_bit_engine u_bit (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .load (load),
    .clr  (clr),
    .len  (state == IDLE ? 6'(HDR_BITS) : 6'd8),
    .data (ld_data),
    .miso (spi_miso_i),
    .sck  (spi_sck_o),
    .mosi (spi_mosi_o),
    .done (done),
    .rx   (rx)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      spi_cs_no <= 1'b1;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      adr_q <= '0;
      dat_q <= '0;
      we_q <= 1'b0;
      dcnt <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      case (state)
        IDLE: if (req) begin
          adr_q <= wbs_adr_i;
          we_q <= wbs_we_i;
          dat_q <= wbs_dat_i;
          state <= idle_go ? HDR : ACK;
          spi_cs_no <= !idle_go;
          wbs_ack_o <= !idle_go;
        end
        HDR: if (clr) begin
          state <= DESEL;
          spi_cs_no <= 1'b1;
        end else if (done) state <= DATA;
        DATA: if (clr) begin
          state <= DESEL;
          spi_cs_no <= 1'b1;
        end else if (done) begin
          wbs_ack_o <= 1'b1;
          if (!we_q) wbs_dat_o <= rx;
          state <= ACK;
        end
        ACK: begin
          state <= spi_cs_no ? IDLE : wbs_cti_i == CTI_INCR ? HOLD : DESEL;
          spi_cs_no <= spi_cs_no | (wbs_cti_i != CTI_INCR);
        end
        HOLD: if (hold_go) begin
          adr_q <= wbs_adr_i;
          dat_q <= wbs_dat_i;
          state <= DATA;
        end else if (!wbs_cyc_i | wbs_stb_i) begin
          state <= DESEL;
          spi_cs_no <= 1'b1;
        end
        DESEL: begin
          dcnt <= !dcnt;
          if (dcnt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wb_spi_sram.sv
// tb_wb_spi_sram: directed bench for wb_spi_sram with a behavioural sequential-mode SPI SRAM
module tb_wb_spi_sram;
  import wb_spi_sram_pkg::*;
  logic clk = 0, rst_n = 0, cyc = 0, stb = 0, we = 0, sel = 0, miso = 0;
  logic [23:0] adr = '0;
  logic [7:0] dat_i = '0;
  logic [2:0] cti = '0;
  logic [1:0] bte = '0;
  logic ack, err, rty, sck, cs_n, mosi;
  logic [7:0] dat_o;
  int tests = 0, fails = 0;
  logic [7:0] mem [0:65535];
  int bitcnt = 0, last_bits = 0, hdr_cnt = 0, ack_cnt = 0, cs_rise = 0, ri = 0;
  logic [31:0] sh = '0, last_hdr = '0;
  logic [7:0] wb = '0, rb = '0;
  int n, h0, c0, a0;
  logic [7:0] r;
  always #5 clk = ~clk;
  wb_spi_sram dut (
    .clk_i(clk), .rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_cti_i(cti), .wbs_bte_i(bte),
    .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty), .wbs_dat_o(dat_o),
    .spi_sck_o(sck), .spi_cs_no(cs_n), .spi_mosi_o(mosi), .spi_miso_i(miso)
  );
  always @(posedge clk) if (ack) ack_cnt++;
  always @(posedge cs_n) cs_rise++;
  always @(posedge sck or posedge cs_n) begin
    if (cs_n) begin
      last_bits = bitcnt;
      bitcnt = 0;
    end else begin
      if (bitcnt < 32) sh = {sh[30:0], mosi};
      else wb = {wb[6:0], mosi};
      bitcnt++;
      if (bitcnt == 32) begin
        last_hdr = sh;
        hdr_cnt++;
      end
      if (bitcnt > 32 && bitcnt % 8 == 0 && last_hdr[31:24] == SPI_WRITE)
        mem[16'(last_hdr[23:0] + 24'((bitcnt - 40) / 8))] = wb;
    end
  end
  always @(negedge sck)
    if (!cs_n && bitcnt >= 32 && last_hdr[31:24] == SPI_READ) begin
      ri = bitcnt - 32;
      rb = mem[16'(last_hdr[23:0] + 24'(ri / 8))];
      #1 miso = rb[3'(7 - ri % 8)];
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [23:0] a, input logic [7:0] d, input logic s,
                      input logic [2:0] c, output int cnt, output logic [7:0] rd);
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s; cti = c;
    @(posedge clk);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!ack && cnt < 300);
    rd = dat_o;
    @(posedge clk);
    #1;
    stb = 0;
    if (c != CTI_INCR) cyc = 0;
  endtask
  task automatic idle3;
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = i[7:0];
    mem[16'hABCD] = 8'h3C;
    mem[16'h0000] = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_sck", 32'(sck), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dat", 32'(dat_o), 0);
    chk("err_rty", 32'({err, rty}), 0);
    @(posedge clk);
    #1 rst_n = 1;
    idle3;
    xfer(1, 24'h001234, 8'hA5, 1, CTI_EOB, n, r);
    chk("wr_ack_cycle", 32'(n), 81);
    chk("wr_hdr", last_hdr, 32'h02001234);
    @(negedge clk);
    chk("wr_cs_hi1", 32'(cs_n), 1);
    chk("wr_bits", 32'(last_bits), 40);
    chk("wr_mem", 32'(mem[16'h1234]), 32'hA5);
    @(negedge clk);
    chk("wr_cs_hi2", 32'(cs_n), 1);
    idle3;
    xfer(0, 24'h00ABCD, 8'h00, 1, CTI_EOB, n, r);
    chk("rd_ack_cycle", 32'(n), 81);
    chk("rd_hdr", last_hdr, 32'h0300ABCD);
    chk("rd_data", 32'(r), 32'h3C);
    idle3;
    h0 = hdr_cnt;
    c0 = cs_rise;
    xfer(0, 24'h000010, 8'h00, 1, CTI_INCR, n, r);
    chk("b0_cycle", 32'(n), 81);
    chk("b0_data", 32'(r), 32'h10);
    xfer(0, 24'h000011, 8'h00, 1, CTI_INCR, n, r);
    chk("b1_cycle", 32'(n), 17);
    chk("b1_data", 32'(r), 32'h11);
    xfer(0, 24'h000012, 8'h00, 1, CTI_INCR, n, r);
    chk("b2_cycle", 32'(n), 17);
    chk("b2_data", 32'(r), 32'h12);
    chk("b_cs_low", 32'(cs_rise), 32'(c0));
    xfer(0, 24'h000013, 8'h00, 1, CTI_EOB, n, r);
    chk("b3_cycle", 32'(n), 17);
    chk("b3_data", 32'(r), 32'h13);
    chk("b_one_hdr", 32'(hdr_cnt), 32'(h0 + 1));
    chk("b_cs_rise", 32'(cs_rise), 32'(c0 + 1));
    idle3;
    xfer(0, 24'h000020, 8'h00, 1, CTI_INCR, n, r);
    chk("j0_data", 32'(r), 32'h20);
    xfer(0, 24'h000040, 8'h00, 1, CTI_EOB, n, r);
    chk("j1_cycle", 32'(n), 84);
    chk("j1_hdr", last_hdr, 32'h03000040);
    chk("j1_data", 32'(r), 32'h40);
    chk("j_hdrs", 32'(hdr_cnt), 32'(h0 + 3));
    idle3;
    h0 = hdr_cnt;
    c0 = cs_rise;
    xfer(1, 24'h000377, 8'hEE, 0, CTI_EOB, n, r);
    chk("sel0_cycle", 32'(n), 1);
    chk("sel0_mem", 32'(mem[16'h0377]), 32'h77);
    chk("sel0_nohdr", 32'(hdr_cnt), 32'(h0));
    chk("sel0_cs", 32'(cs_rise), 32'(c0));
    chk("dat_hold", 32'(dat_o), 32'h40);
    idle3;
    a0 = ack_cnt;
    cyc = 1; stb = 1; we = 1; adr = 24'h000500; dat_i = 8'h99; sel = 1; cti = CTI_EOB;
    @(posedge clk);
    repeat (21) @(posedge clk);
    #1 cyc = 0;
    stb = 0;
    @(negedge clk);
    chk("ab_active", 32'(cs_n), 0);
    @(negedge clk);
    chk("ab_cs_hi", 32'(cs_n), 1);
    chk("ab_sck", 32'(sck), 0);
    chk("ab_bits", 32'(last_bits), 11);
    repeat (4) @(negedge clk);
    chk("ab_noack", 32'(ack_cnt), 32'(a0));
    idle3;
    xfer(0, 24'h000005, 8'h00, 1, CTI_EOB, n, r);
    chk("ab_next_cycle", 32'(n), 81);
    chk("ab_next_data", 32'(r), 32'h05);
    idle3;
    cyc = 1; stb = 1; we = 0; adr = 24'h000007; sel = 1; cti = CTI_EOB;
    @(posedge clk);
    repeat (70) @(posedge clk);
    #2;
    chk("rs_active", 32'(cs_n), 0);
    rst_n = 0;
    #1;
    chk("rs_cs", 32'(cs_n), 1);
    chk("rs_sck", 32'(sck), 0);
    chk("rs_ack", 32'(ack), 0);
    chk("rs_dat", 32'(dat_o), 0);
    @(posedge clk);
    #1 cyc = 0;
    stb = 0;
    @(posedge clk);
    #1 rst_n = 1;
    idle3;
    xfer(0, 24'h000000, 8'h00, 1, CTI_EOB, n, r);
    chk("rs_next_cycle", 32'(n), 81);
    chk("rs_next_hdr", last_hdr, 32'h03000000);
    chk("rs_next_data", 32'(r), 32'h5A);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
